// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS MEM-stage data-memory sequencer.
//   DataW    : datapath width
//   REG_ZERO : architectural $0, never a forwarding source
//   dmem_state_e : sequencer states (idle -> wait -> done)
package mips_pkg;

  localparam int unsigned DataW = 32;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StDone = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/store_fwd_sel.sv
// WB-to-MEM store-data forwarding: compare and mux.
// Inputs : mem_write_i, mem_rt_i, mem_wdata_i (EX/MEM store operand),
//          wb_reg_write_i, wb_mem_to_reg_i, wb_rd_i, wb_data_i (MEM/WB load result)
// Outputs: fwd_o (forwarding taken), wdata_o (selected store data)
module store_fwd_sel
  import mips_pkg::*;
(
  input  logic             mem_write_i,
  input  logic [4:0]       mem_rt_i,
  input  logic [DataW-1:0] mem_wdata_i,
  input  logic             wb_reg_write_i,
  input  logic             wb_mem_to_reg_i,
  input  logic [4:0]       wb_rd_i,
  input  logic [DataW-1:0] wb_data_i,
  output logic             fwd_o,
  output logic [DataW-1:0] wdata_o
);

  // Only a load in WB writing the store's source register needs bypassing; $0 is never real.
  always_comb begin
    fwd_o   = mem_write_i & wb_reg_write_i & wb_mem_to_reg_i &
              (wb_rd_i == mem_rt_i) & (mem_rt_i != REG_ZERO);
    wdata_o = fwd_o ? wb_data_i : mem_wdata_i;
  end

endmodule

// File: rtl/dmem_sequencer.sv
// MEM-stage data-memory sequencer with req/ack handshake and watchdog.
// Inputs : clk, reset_n (sync, active low), mem_read/mem_write/mem_addr/mem_wdata/mem_rt
//          (EX/MEM), wb_reg_write/wb_mem_to_reg/wb_rd/wb_data (MEM/WB), dm_ack/dm_rdata.
// Outputs: dm_req/dm_we/dm_addr/dm_wdata (registered request), stall (combinational),
//          ld_data/ld_valid (load result), fwd_used, err (timeout or read+write pulse).
module dmem_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             mem_read,
  input  logic             mem_write,
  input  logic [DataW-1:0] mem_addr,
  input  logic [DataW-1:0] mem_wdata,
  input  logic [4:0]       mem_rt,
  input  logic             wb_reg_write,
  input  logic             wb_mem_to_reg,
  input  logic [4:0]       wb_rd,
  input  logic [DataW-1:0] wb_data,
  input  logic             dm_ack,
  input  logic [DataW-1:0] dm_rdata,
  output logic             dm_req,
  output logic             dm_we,
  output logic [DataW-1:0] dm_addr,
  output logic [DataW-1:0] dm_wdata,
  output logic             stall,
  output logic [DataW-1:0] ld_data,
  output logic             ld_valid,
  output logic             fwd_used,
  output logic             err
);

  localparam int unsigned CntW = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);

  dmem_state_e state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             dm_req_q, dm_req_d;
  logic             dm_we_q, dm_we_d;
  logic [DataW-1:0] dm_addr_q, dm_addr_d;
  logic [DataW-1:0] dm_wdata_q, dm_wdata_d;
  logic [DataW-1:0] ld_data_q, ld_data_d;
  logic             fwd_used_q, fwd_used_d;
  logic             err_q, err_d;

  logic             fwd;
  logic [DataW-1:0] fwd_data;

  store_fwd_sel u_store_fwd_sel (
    .mem_write_i     (mem_write),
    .mem_rt_i        (mem_rt),
    .mem_wdata_i     (mem_wdata),
    .wb_reg_write_i  (wb_reg_write),
    .wb_mem_to_reg_i (wb_mem_to_reg),
    .wb_rd_i         (wb_rd),
    .wb_data_i       (wb_data),
    .fwd_o           (fwd),
    .wdata_o         (fwd_data)
  );

  // stall depends only on state and op inputs so dm_ack stays off the pipeline stall path.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dm_req_d   = dm_req_q;
    dm_we_d    = dm_we_q;
    dm_addr_d  = dm_addr_q;
    dm_wdata_d = dm_wdata_q;
    ld_data_d  = ld_data_q;
    fwd_used_d = fwd_used_q;
    err_d      = 1'b0;
    stall      = 1'b0;
    ld_valid   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (mem_read | mem_write) begin
          stall      = 1'b1;
          dm_req_d   = 1'b1;
          dm_we_d    = mem_write;  // read+write resolves to a write
          dm_addr_d  = mem_addr;
          dm_wdata_d = fwd_data;
          fwd_used_d = fwd;
          cnt_d      = '0;
          err_d      = mem_read & mem_write;
          state_d    = StWait;
        end
      end
      StWait: begin
        stall = 1'b1;
        if (dm_ack) begin
          if (!dm_we_q) ld_data_d = dm_rdata;
          dm_req_d = 1'b0;
          state_d  = StDone;
        end else if (cnt_q == CntLast) begin
          if (!dm_we_q) ld_data_d = '0;
          dm_req_d = 1'b0;
          err_d    = 1'b1;
          state_d  = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        // Op inputs still show the finishing instruction here; ignoring them avoids a re-issue.
        ld_valid   = ~dm_we_q;
        fwd_used_d = 1'b0;
        state_d    = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      dm_req_q   <= 1'b0;
      dm_we_q    <= 1'b0;
      dm_addr_q  <= '0;
      dm_wdata_q <= '0;
      ld_data_q  <= '0;
      fwd_used_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dm_req_q   <= dm_req_d;
      dm_we_q    <= dm_we_d;
      dm_addr_q  <= dm_addr_d;
      dm_wdata_q <= dm_wdata_d;
      ld_data_q  <= ld_data_d;
      fwd_used_q <= fwd_used_d;
      err_q      <= err_d;
    end
  end

  assign dm_req   = dm_req_q;
  assign dm_we    = dm_we_q;
  assign dm_addr  = dm_addr_q;
  assign dm_wdata = dm_wdata_q;
  assign ld_data  = ld_data_q;
  assign fwd_used = fwd_used_q;
  assign err      = err_q;

endmodule
